// File: rtl/hu_audiodec_dma64_rd_unpack.sv
// Read-side DMA front end for the audio decoder.
// Issues one 64-bit DMA read per command and unpacks the beats into 32-bit words, low half first.
module hu_audiodec_dma64_rd_unpack #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_index,
  input  logic [CNT_W-1:0] cmd_words,
  output logic             dma_read_ctrl_valid,
  input  logic             dma_read_ctrl_ready,
  output logic [31:0]      dma_read_ctrl_data_index,
  output logic [31:0]      dma_read_ctrl_data_length,
  output logic [2:0]       dma_read_ctrl_data_size,
  input  logic             dma_read_chnl_valid,
  output logic             dma_read_chnl_ready,
  input  logic [63:0]      dma_read_chnl_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ZERO = 2'd1;
  localparam logic [1:0] S_REQ  = 2'd2;
  localparam logic [1:0] S_XFER = 2'd3;

  logic [1:0]       state;
  logic [31:0]      index_q;
  logic [CNT_W-1:0] words_rem;
  logic [CNT_W-1:0] beats_rem;
  logic             half;
  logic             done_q;

  logic [63:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  logic [CNT_W:0]   beats_sum;
  logic             fifo_full;
  logic             fifo_empty;
  logic             cmd_hs;
  logic             push;
  logic             pop;
  logic             out_hs;
  logic             last_word;

  // Extra bit keeps the round-up from wrapping when cmd_words is all ones.
  assign beats_sum  = {1'b0, cmd_words} + {{CNT_W{1'b0}}, 1'b1};

  assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign last_word  = (words_rem == CNT_W'(1));

  assign cmd_ready  = (state == S_IDLE);
  assign cmd_hs     = cmd_valid & cmd_ready;

  assign dma_read_ctrl_valid       = (state == S_REQ);
  assign dma_read_ctrl_data_index  = dma_read_ctrl_valid ? index_q : 32'd0;
  assign dma_read_ctrl_data_length = dma_read_ctrl_valid ? 32'(beats_rem) : 32'd0;
  assign dma_read_ctrl_data_size   = dma_read_ctrl_valid ? 3'b011 : 3'b000;

  assign dma_read_chnl_ready = (state == S_XFER) & ~fifo_full & (beats_rem != '0);
  assign push                = dma_read_chnl_valid & dma_read_chnl_ready;

  // FIFO storage is not reset, so the word is masked whenever nothing is valid.
  assign out_valid = (state == S_XFER) & ~fifo_empty;
  assign out_data  = !out_valid ? 32'd0 :
                     half       ? mem[rd_ptr][63:32] : mem[rd_ptr][31:0];
  assign out_last  = out_valid & last_word;
  assign out_hs    = out_valid & out_ready;
  assign pop       = out_hs & (last_word | half);

  assign busy = (state != S_IDLE);
  assign done = (state == S_ZERO) | done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      index_q   <= '0;
      words_rem <= '0;
      beats_rem <= '0;
      half      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_hs) begin
            index_q   <= cmd_index;
            words_rem <= cmd_words;
            beats_rem <= beats_sum[CNT_W:1];
            half      <= 1'b0;
            state     <= (cmd_words == '0) ? S_ZERO : S_REQ;
          end
        end
        S_ZERO: state <= S_IDLE;
        S_REQ: begin
          if (dma_read_ctrl_ready) state <= S_XFER;
        end
        S_XFER: begin
          if (push) beats_rem <= beats_rem - CNT_W'(1);
          if (out_hs) begin
            words_rem <= words_rem - CNT_W'(1);
            if (last_word) begin
              half   <= 1'b0;
              done_q <= 1'b1;
              state  <= S_IDLE;
            end else begin
              half <= ~half;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dma_read_chnl_data;
  end

endmodule

// File: tb/tb_hu_audiodec_dma64_rd_unpack.sv
// Self-checking bench for hu_audiodec_dma64_rd_unpack: per-cycle vector table plus
// hand-written sequences for back-pressure, control stall, zero-length and mid-transfer reset.
module tb_hu_audiodec_dma64_rd_unpack;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_index = '0;
  logic [31:0] cmd_words = '0;
  logic        dma_read_ctrl_valid;
  logic        dma_read_ctrl_ready = 1'b0;
  logic [31:0] dma_read_ctrl_data_index;
  logic [31:0] dma_read_ctrl_data_length;
  logic [2:0]  dma_read_ctrl_data_size;
  logic        dma_read_chnl_valid = 1'b0;
  logic        dma_read_chnl_ready;
  logic [63:0] dma_read_chnl_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  hu_audiodec_dma64_rd_unpack #(.FIFO_DEPTH(4), .CNT_W(32)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .cmd_valid                (cmd_valid),
    .cmd_ready                (cmd_ready),
    .cmd_index                (cmd_index),
    .cmd_words                (cmd_words),
    .dma_read_ctrl_valid      (dma_read_ctrl_valid),
    .dma_read_ctrl_ready      (dma_read_ctrl_ready),
    .dma_read_ctrl_data_index (dma_read_ctrl_data_index),
    .dma_read_ctrl_data_length(dma_read_ctrl_data_length),
    .dma_read_ctrl_data_size  (dma_read_ctrl_data_size),
    .dma_read_chnl_valid      (dma_read_chnl_valid),
    .dma_read_chnl_ready      (dma_read_chnl_ready),
    .dma_read_chnl_data       (dma_read_chnl_data),
    .out_valid                (out_valid),
    .out_ready                (out_ready),
    .out_data                 (out_data),
    .out_last                 (out_last),
    .busy                     (busy),
    .done                     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cmd_valid;
    logic [31:0] cmd_index;
    logic [31:0] cmd_words;
    logic        ctrl_ready;
    logic        chnl_valid;
    logic [63:0] chnl_data;
    logic        out_ready;
    logic        e_cmd_ready;
    logic        e_ctrl_valid;
    logic [31:0] e_ctrl_index;
    logic [31:0] e_ctrl_length;
    logic        e_chnl_ready;
    logic        e_out_valid;
    logic [31:0] e_out_data;
    logic        e_out_last;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(
    input logic cv, input logic [31:0] ci, input logic [31:0] cw, input logic crd,
    input logic chv, input logic [63:0] chd, input logic ord,
    input logic ecr, input logic ectv, input logic [31:0] ecti, input logic [31:0] ectl,
    input logic echr, input logic eov, input logic [31:0] eod, input logic eol,
    input logic eb, input logic ed);
    vec_t v;
    v.cmd_valid = cv;  v.cmd_index = ci;  v.cmd_words = cw;  v.ctrl_ready = crd;
    v.chnl_valid = chv; v.chnl_data = chd; v.out_ready = ord;
    v.e_cmd_ready = ecr; v.e_ctrl_valid = ectv; v.e_ctrl_index = ecti; v.e_ctrl_length = ectl;
    v.e_chnl_ready = echr; v.e_out_valid = eov; v.e_out_data = eod; v.e_out_last = eol;
    v.e_busy = eb; v.e_done = ed;
    return v;
  endfunction

  function automatic logic [63:0] mk_beat(input logic [31:0] base, input int b);
    logic [31:0] lo;
    lo = base + 32'(2 * b);
    return {lo + 32'd1, lo};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    cmd_valid           = v.cmd_valid;
    cmd_index           = v.cmd_index;
    cmd_words           = v.cmd_words;
    dma_read_ctrl_ready = v.ctrl_ready;
    dma_read_chnl_valid = v.chnl_valid;
    dma_read_chnl_data  = v.chnl_data;
    out_ready           = v.out_ready;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " cmd_ready"},   64'(cmd_ready), 64'd1);
    checkOutput({tag, " ctrl_valid"},  64'(dma_read_ctrl_valid), 64'd0);
    checkOutput({tag, " ctrl_index"},  64'(dma_read_ctrl_data_index), 64'd0);
    checkOutput({tag, " ctrl_length"}, 64'(dma_read_ctrl_data_length), 64'd0);
    checkOutput({tag, " ctrl_size"},   64'(dma_read_ctrl_data_size), 64'd0);
    checkOutput({tag, " chnl_ready"},  64'(dma_read_chnl_ready), 64'd0);
    checkOutput({tag, " out_valid"},   64'(out_valid), 64'd0);
    checkOutput({tag, " out_data"},    64'(out_data), 64'd0);
    checkOutput({tag, " out_last"},    64'(out_last), 64'd0);
    checkOutput({tag, " busy"},        64'(busy), 64'd0);
    checkOutput({tag, " done"},        64'(done), 64'd0);
  endtask

  task automatic startCmd(input logic [31:0] idx, input logic [31:0] words);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_index = idx;
    cmd_words = words;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic grantReq();
    dma_read_ctrl_ready = 1'b1;
    @(negedge clk);
    dma_read_ctrl_ready = 1'b0;
  endtask

  // Entered at a negedge in XFER; streams beats starting at first_beat and drains all words.
  task automatic drainTransfer(input string tag, input int nwords, input logic [31:0] base,
                               input int first_beat, input bit check_release);
    int nbeats = (nwords + 1) / 2;
    int beat_idx = first_beat;
    int w = 0;
    int cycles = 0;
    out_ready = 1'b1;
    while (w < nwords && cycles < 200) begin
      if (check_release && w == 1 && out_valid)
        checkOutput({tag, " chnl_ready before pop"}, 64'(dma_read_chnl_ready), 64'd0);
      if (check_release && w == 2 && out_valid)
        checkOutput({tag, " chnl_ready after pop"}, 64'(dma_read_chnl_ready), 64'd1);
      dma_read_chnl_valid = (beat_idx < nbeats);
      dma_read_chnl_data  = mk_beat(base, beat_idx);
      if (dma_read_chnl_ready && dma_read_chnl_valid) beat_idx++;
      if (out_valid) begin
        checkOutput($sformatf("%s word%0d data", tag, w), 64'(out_data), 64'(base + 32'(w)));
        checkOutput($sformatf("%s word%0d last", tag, w), 64'(out_last), 64'(w == nwords - 1));
        w++;
      end
      @(negedge clk);
      cycles++;
    end
    dma_read_chnl_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (w != nwords) begin
      errors++;
      $display("[TB] FAIL %s timeout words=%0d expected=%0d", tag, w, nwords);
    end
    checkOutput({tag, " done pulse"}, 64'(done), 64'd1);
    checkOutput({tag, " busy after"}, 64'(busy), 64'd0);
    @(negedge clk);
    checkOutput({tag, " done cleared"}, 64'(done), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int accepted;

    // 4-word transfer at index 0x40
    vecs.push_back(mkv(1, 32'h40, 4, 0, 0, 64'h0, 0,  1, 0, 0, 0,       0, 0, 0,            0, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 1, 0, 64'h0, 0,       0, 1, 32'h40, 2, 0, 0, 0,            0, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 1, 64'hBBBB0002_AAAA0001, 1, 0, 0, 0, 0, 1, 0, 0,       0, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 1, 64'hDDDD0004_CCCC0003, 1, 0, 0, 0, 0, 1, 1, 32'hAAAA0001, 0, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 64'h0, 1,       0, 0, 0, 0,       0, 1, 32'hBBBB0002, 0, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 64'h0, 1,       0, 0, 0, 0,       0, 1, 32'hCCCC0003, 0, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 64'h0, 1,       0, 0, 0, 0,       0, 1, 32'hDDDD0004, 1, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 64'h0, 0,       1, 0, 0, 0,       0, 0, 0,            0, 0, 1));
    // 3-word transfer, accepted the cycle after done; high half of the second beat dropped
    vecs.push_back(mkv(1, 32'h10, 3, 0, 0, 64'h0, 0,  1, 0, 0, 0,       0, 0, 0,            0, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 1, 0, 64'h0, 0,       0, 1, 32'h10, 2, 0, 0, 0,            0, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 1, 64'h22222222_11111111, 1, 0, 0, 0, 0, 1, 0, 0,       0, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 1, 64'h44444444_33333333, 1, 0, 0, 0, 0, 1, 1, 32'h11111111, 0, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 64'h0, 1,       0, 0, 0, 0,       0, 1, 32'h22222222, 0, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 64'h0, 1,       0, 0, 0, 0,       0, 1, 32'h33333333, 1, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 64'h0, 0,       1, 0, 0, 0,       0, 0, 0,            0, 0, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 64'h0, 0,       1, 0, 0, 0,       0, 0, 0,            0, 0, 0));

    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      checkOutput($sformatf("v%0d cmd_ready", i),  64'(cmd_ready), 64'(vecs[i].e_cmd_ready));
      checkOutput($sformatf("v%0d ctrl_valid", i), 64'(dma_read_ctrl_valid), 64'(vecs[i].e_ctrl_valid));
      if (vecs[i].e_ctrl_valid) begin
        checkOutput($sformatf("v%0d ctrl_index", i),  64'(dma_read_ctrl_data_index), 64'(vecs[i].e_ctrl_index));
        checkOutput($sformatf("v%0d ctrl_length", i), 64'(dma_read_ctrl_data_length), 64'(vecs[i].e_ctrl_length));
        checkOutput($sformatf("v%0d ctrl_size", i),   64'(dma_read_ctrl_data_size), 64'd3);
      end
      checkOutput($sformatf("v%0d chnl_ready", i), 64'(dma_read_chnl_ready), 64'(vecs[i].e_chnl_ready));
      checkOutput($sformatf("v%0d out_valid", i),  64'(out_valid), 64'(vecs[i].e_out_valid));
      if (vecs[i].e_out_valid)
        checkOutput($sformatf("v%0d out_data", i), 64'(out_data), 64'(vecs[i].e_out_data));
      checkOutput($sformatf("v%0d out_last", i),   64'(out_last), 64'(vecs[i].e_out_last));
      checkOutput($sformatf("v%0d busy", i),       64'(busy), 64'(vecs[i].e_busy));
      checkOutput($sformatf("v%0d done", i),       64'(done), 64'(vecs[i].e_done));
      applyStimulus(vecs[i]);
    end

    // zero-length command: done and busy for exactly one cycle, no DMA request
    startCmd(32'h5, 32'd0);
    checkOutput("zero busy",       64'(busy), 64'd1);
    checkOutput("zero done",       64'(done), 64'd1);
    checkOutput("zero ctrl_valid", 64'(dma_read_ctrl_valid), 64'd0);
    checkOutput("zero cmd_ready",  64'(cmd_ready), 64'd0);
    @(negedge clk);
    checkOutput("zero busy after",  64'(busy), 64'd0);
    checkOutput("zero done after",  64'(done), 64'd0);
    checkOutput("zero ctrl after",  64'(dma_read_ctrl_valid), 64'd0);
    checkOutput("zero cmd_ready after", 64'(cmd_ready), 64'd1);

    // control request stalled for 5 cycles while beats are offered early
    startCmd(32'h77, 32'd2);
    dma_read_chnl_valid = 1'b1;
    dma_read_chnl_data  = 64'hDEAD_BEEF_DEAD_BEEF;
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("stall%0d ctrl_valid", k),  64'(dma_read_ctrl_valid), 64'd1);
      checkOutput($sformatf("stall%0d ctrl_index", k),  64'(dma_read_ctrl_data_index), 64'h77);
      checkOutput($sformatf("stall%0d ctrl_length", k), 64'(dma_read_ctrl_data_length), 64'd1);
      checkOutput($sformatf("stall%0d chnl_ready", k),  64'(dma_read_chnl_ready), 64'd0);
      @(negedge clk);
    end
    dma_read_chnl_valid = 1'b0;
    grantReq();
    drainTransfer("stall", 2, 32'h7000_0000, 0, 1'b0);

    // back-pressure: 6 beats offered, only FIFO_DEPTH accepted while out_ready is low
    startCmd(32'h100, 32'd12);
    grantReq();
    accepted = 0;
    for (int k = 0; k < 8; k++) begin
      dma_read_chnl_valid = (accepted < 6);
      dma_read_chnl_data  = mk_beat(32'h1000_0000, accepted);
      if (dma_read_chnl_ready && dma_read_chnl_valid) accepted++;
      @(negedge clk);
    end
    checkOutput("bp accepted", 64'(accepted), 64'd4);
    checkOutput("bp chnl_ready full", 64'(dma_read_chnl_ready), 64'd0);
    checkOutput("bp out_valid held", 64'(out_valid), 64'd1);
    drainTransfer("bp", 12, 32'h1000_0000, accepted, 1'b1);

    // reset mid-transfer after one of two beats
    startCmd(32'h20, 32'd4);
    grantReq();
    dma_read_chnl_valid = 1'b1;
    dma_read_chnl_data  = 64'hFFFF0002_FFFF0001;
    @(negedge clk);
    dma_read_chnl_valid = 1'b0;
    checkOutput("midrst out_valid before", 64'(out_valid), 64'd1);
    #2 rst = 1'b0;
    #1 checkResetOutputs("midrst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst no done", 64'(done), 64'd0);
    checkOutput("midrst idle", 64'(busy), 64'd0);
    startCmd(32'h30, 32'd2);
    checkOutput("recover ctrl_length", 64'(dma_read_ctrl_data_length), 64'd1);
    grantReq();
    drainTransfer("recover", 2, 32'h5A5A_0000, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
